axi4_stream_pkt_defrag: RTL
===========================

AXI4_STREAM_PKT_DEFRAG -- requirements
Module: axi4_stream_pkt_defrag

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 64, meaning data width in bits; a multiple of 8. W = TDATA_WIDTH/8.
REQ-002 SHALL have parameters TID_WIDTH, TDEST_WIDTH and TUSER_WIDTH, each default 1, each the width of the matching sideband.
REQ-003 SHALL have port clk_i, input, 1 bit, the clock.
REQ-004 SHALL have port rst_i, input, 1 bit, reset; asynchronous and active-high.
REQ-005 SHALL have port pkt_i, axi4_stream_if.slave, the fragment stream in; on a tlast beat, tuser[0]=1 marks the end of the original packet.
REQ-006 SHALL have port pkt_o, axi4_stream_if.master, the reassembled packet stream out.
REQ-007 SHALL have port frags_o, output, 16 bits, the fragment count of the last completed packet.

Function
REQ-008 SHALL concatenate consecutive input fragments, byte-contiguously, into one output packet.
REQ-009 SHALL end the packet at the input beat where tlast=1 and tuser[0]=1 (EOP beat).
REQ-010 SHALL count input beat bytes as: W on non-tlast beats; on tlast beats, the index of the highest set tkeep bit plus 1 (0 if tkeep=0).
REQ-011 SHALL hold data in a 2W-byte buffer with a fill count cnt (0..2W), and append new bytes starting at byte offset cnt.
REQ-012 SHALL pack output bytes LSB-aligned, and emit them in input order with no gaps.
REQ-013 SHALL use a state machine with states IDLE, COLLECT and FLUSH.
REQ-014 SHALL move IDLE->COLLECT on the first accepted beat; on that beat it latches tid, tdest and tuser.
REQ-015 SHALL move COLLECT->FLUSH when the EOP beat is accepted.
REQ-016 SHALL move FLUSH->IDLE on the handshake of the output tlast beat.
REQ-017 SHALL go IDLE->FLUSH directly if the first accepted beat is itself the EOP beat.
REQ-018 SHALL drive pkt_i.tready = !rst_i && state!=FLUSH && cnt<=W; tready SHALL NOT depend on pkt_o.tready.
REQ-019 SHALL assert pkt_o.tvalid when cnt>=W, or when state=FLUSH; the value is registered state only.
REQ-020 SHALL, outside FLUSH, emit only full words (tkeep all ones, tlast=0).
REQ-021 SHALL, in FLUSH, emit words of min(cnt,W) bytes, with tkeep set to ones for those bytes; tlast=1 when cnt<=W.
REQ-022 SHALL, when an EOP beat is accepted with cnt=0 and no bytes were accepted for the packet, emit one beat with tkeep=0, tlast=1.
REQ-023 SHALL, on a simultaneous rx and tx handshake, update cnt to cnt + rx_bytes - tx_bytes and shift the buffer down by tx_bytes in the same cycle.
REQ-024 SHALL give an input byte a latency of 1 cycle minimum from the accepting handshake to its appearance on pkt_o.
REQ-025 SHALL drive pkt_o.tstrb equal to pkt_o.tkeep.
REQ-026 SHALL hold tid, tdest and tuser constant on all output beats of a packet, at the values latched in REQ-014.
REQ-027 SHALL count tlast beats of the packet, saturating at 16'hFFFF.
REQ-028 SHALL load that count into frags_o on the output tlast handshake.
REQ-029 SHALL hold the output data, tkeep and tlast stable while tvalid=1 and tready=0.
REQ-030 SHALL ignore input tuser[0] on non-tlast beats.

Reset
REQ-031 SHALL, while rst_i=1, set state=IDLE and cnt=0.
REQ-032 SHALL, while rst_i=1, set pkt_o.tvalid=0, tlast=0, tkeep=0, frags_o=0, pkt_i.tready=0, and latched sidebands=0.
REQ-033 SHALL discard a partial packet when reset occurs mid-packet; the first beat after reset release SHALL start a new packet.

Structure
REQ-034 SHALL place the state enum (IDLE, COLLECT, FLUSH) in shared package axi4_stream_pkg.
REQ-035 SHALL place the keep-to-byte-count function in shared package axi4_stream_pkg.
REQ-036 SHALL implement the byte-append/shift buffer in one sub-module, axi4_stream_byte_buf, with parameter W and ports push bytes, pop bytes and cnt.

Verification (W=8)
REQ-037 SHALL cover a single 20-byte fragment (tkeep FF,FF,0F, EOP): out FF,FF,0F with tlast on beat 3 and frags_o=1.
REQ-038 SHALL cover 12B+12B fragments (FF,0F; FF,0F with EOP): out FF,FF,FF with bytes 0..23 in order, tlast on beat 3 and frags_o=2.
REQ-039 SHALL cover three 3-byte single-beat fragments (tkeep 07, EOP on the 3rd): out FF, then 01 with tlast, and frags_o=3.
REQ-040 SHALL cover REQ-038 with pkt_o.tready random at 50%: identical output, no dropped or duplicated bytes, and beats stable while stalled.
REQ-041 SHALL cover rst_i pulsed after 2 accepted beats of a packet: tvalid=0 immediately, then a following 8-byte EOP packet gives one FF beat with tlast.
REQ-042 SHALL cover an EOP beat with tkeep=00 in IDLE: one output beat with tkeep=00, tlast=1 and frags_o=1.

Source files
------------

// File: rtl/axi4_stream_pkg.sv
// axi4_stream_pkg: shared FSM state type and tkeep byte-count helper for AXI4-Stream blocks
package axi4_stream_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;
  // Bytes on a tlast beat: highest set keep bit + 1, zero when keep is empty
  function automatic logic [7:0] keep_bytes(input logic [127:0] keep);
    keep_bytes = '0;
    for (int i = 0; i < 128; i++) if (keep[i]) keep_bytes = 8'(i + 1);
  endfunction
endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: AXI4-Stream bundle with master/slave views
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 64,
  parameter int TID_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  logic tvalid, tready, tlast;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep, tstrb;
  logic [TID_WIDTH-1:0] tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  modport master(output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
  modport slave(input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi4_stream_byte_buf.sv
// axi4_stream_byte_buf: 2W-byte append-at-fill / shift-down-on-pop byte buffer
module axi4_stream_byte_buf #(
  parameter int W = 8,
  parameter int CW = $clog2(2 * W + 1)
) (
  input logic clk_i,
  input logic rst_i,
  input logic [8*W-1:0] data,
  input logic [CW-1:0] push,
  input logic [CW-1:0] pop,
  output logic [8*W-1:0] head,
  output logic [CW-1:0] cnt
);
  logic [16*W-1:0] data_q, app, nxt;
  logic [CW-1:0] cnt_nxt;
  // Bytes above the fill level are cleared so unkept lanes never leak out
  always_comb begin
    cnt_nxt = cnt + push - pop;
    app = (data_q & ~({(16*W){1'b1}} << {cnt, 3'b0})) | ((16*W)'(data) << {cnt, 3'b0});
    nxt = (app >> {pop, 3'b0}) & ~({(16*W){1'b1}} << {cnt_nxt, 3'b0});
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt <= '0;
    end else begin
      data_q <= nxt;
      cnt <= cnt_nxt;
    end
  end
  assign head = data_q[8*W-1:0];
endmodule

// File: rtl/axi4_stream_pkt_defrag.sv
// axi4_stream_pkt_defrag: merges tlast-delimited fragments into one packet ending at tlast&&tuser[0]
module axi4_stream_pkt_defrag
  import axi4_stream_pkg::*;
#(
  parameter int TDATA_WIDTH = 64,
  parameter int TID_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
) (
  input logic clk_i,
  input logic rst_i,
  axi4_stream_if.slave pkt_i,
  axi4_stream_if.master pkt_o,
  output logic [15:0] frags_o
);
  localparam int W = TDATA_WIDTH / 8;
  localparam int CW = $clog2(2 * W + 1);
  state_t state;
  logic [CW-1:0] cnt, push, pop, txb;
  logic [TDATA_WIDTH-1:0] head;
  logic [W:0] one_hot;
  logic rx_fire, tx_fire, eop;
  logic [15:0] frag_cnt;
  logic [TID_WIDTH-1:0] tid_q;
  logic [TDEST_WIDTH-1:0] tdest_q;
  logic [TUSER_WIDTH-1:0] tuser_q;
  always_comb begin
    rx_fire = pkt_i.tvalid && pkt_i.tready;
    tx_fire = pkt_o.tvalid && pkt_o.tready;
    eop = pkt_i.tlast && pkt_i.tuser[0];
    push = rx_fire ? (pkt_i.tlast ? CW'(keep_bytes(128'(pkt_i.tkeep))) : CW'(W)) : '0;
    txb = cnt >= CW'(W) ? CW'(W) : cnt;
    pop = tx_fire ? txb : '0;
    one_hot = (W + 1)'(1) << txb;
  end
  axi4_stream_byte_buf #(.W(W), .CW(CW)) u_buf (
    .clk_i(clk_i), .rst_i(rst_i), .data(pkt_i.tdata), .push(push), .pop(pop), .head(head), .cnt(cnt)
  );
  assign pkt_i.tready = !rst_i && state != FLUSH && cnt <= CW'(W);
  assign pkt_o.tvalid = state == FLUSH || cnt >= CW'(W);
  assign pkt_o.tlast = state == FLUSH && cnt <= CW'(W);
  assign pkt_o.tkeep = state == FLUSH ? one_hot[W-1:0] - W'(1) : {W{cnt >= CW'(W)}};
  assign pkt_o.tstrb = pkt_o.tkeep;
  assign pkt_o.tdata = head;
  assign pkt_o.tid = tid_q;
  assign pkt_o.tdest = tdest_q;
  assign pkt_o.tuser = tuser_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      frag_cnt <= '0;
      frags_o <= '0;
      tid_q <= '0;
      tdest_q <= '0;
      tuser_q <= '0;
    end else begin
      if (rx_fire && state == IDLE) begin
        tid_q <= pkt_i.tid;
        tdest_q <= pkt_i.tdest;
        tuser_q <= pkt_i.tuser;
      end
      if (rx_fire && pkt_i.tlast && frag_cnt != 16'hFFFF) frag_cnt <= frag_cnt + 16'd1;
      if (tx_fire && pkt_o.tlast) begin
        frags_o <= frag_cnt;
        frag_cnt <= '0;
      end
      state <= state == FLUSH ? (tx_fire && pkt_o.tlast ? IDLE : FLUSH)
             : rx_fire ? (eop ? FLUSH : COLLECT) : state;
    end
  end
endmodule
